// File: rtl/sr_ctrl_pkg.sv
// Shared constants and types for the SR flip-flop controller.
package sr_ctrl_pkg;

    localparam int DEB_CYCLES_DEF = 4;  // stable synchronized cycles to accept a level change
    localparam int CNT_W_DEF      = 8;  // width of each issued-pulse counter
    localparam int DEB_CNT_W      = 8;  // width of the per-channel debounce counter

    typedef logic [DEB_CNT_W-1:0] deb_cnt_t;

    // Outcome of one arbitration cycle.
    typedef enum logic [1:0] {
        ARB_NONE,
        ARB_SET,
        ARB_CLR
    } arb_t;

endpackage

// File: rtl/sr_ctrl_if.sv
// Signal bundle between the controller and its environment.
interface sr_ctrl_if #(
    parameter int CNT_W = sr_ctrl_pkg::CNT_W_DEF
);
    logic             set_in;   // raw asynchronous set request
    logic             clr_in;   // raw asynchronous clear request
    logic             q_fb;     // Q fed back from the downstream SR flip-flop
    logic             S;        // registered set pulse
    logic             R;        // registered reset pulse
    logic             busy;     // debounce or deferred set in progress
    logic [CNT_W-1:0] set_cnt;  // issued S pulses, saturating
    logic [CNT_W-1:0] clr_cnt;  // issued R pulses, saturating

    modport master (
        output set_in, clr_in, q_fb,
        input  S, R, busy, set_cnt, clr_cnt
    );

    modport slave (
        input  set_in, clr_in, q_fb,
        output S, R, busy, set_cnt, clr_cnt
    );
endinterface

// File: rtl/sr_debounce.sv
// One input channel: 2-flop synchronizer, debounce counter and a
// registered one-cycle pulse on each accepted 0->1 level change.
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o,
    output logic busy_o
);

    localparam deb_cnt_t LAST = deb_cnt_t'(DEB_CYCLES - 1);

    logic     sync1_q, sync2_q;
    logic     level_q, level_d;
    logic     rise_q, rise_d;
    deb_cnt_t cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; toggle the level on the last one.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and debounce state; a reset discards any partial count.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: reset is asynchronous active-low, so it sits in the sensitivity list.
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments let the two synchronizer flops shift in one edge.
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/sr_ctrl.sv
// SR flip-flop controller: debounces set/clear requests, suppresses
// redundant ones against Q, defers a set that collides with a clear,
// and counts the pulses it issues.
module sr_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic     clock,
    input  logic     reset,
    sr_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             set_req, clr_req;
    logic             set_busy, clr_busy;
    arb_t             arb;
    logic             pend_q, pend_d;
    logic             s_q, r_q;
    logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clock  (clock),
        .reset  (reset),
        .raw_i  (bus.set_in),
        .rise_o (set_req),
        .busy_o (set_busy)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clock  (clock),
        .reset  (reset),
        .raw_i  (bus.clr_in),
        .rise_o (clr_req),
        .busy_o (clr_busy)
    );

    // Clear wins any collision; a colliding set waits one cycle, and a
    // request that would not change Q is dropped without a count.
    always_comb begin
        arb    = ARB_NONE;
        pend_d = 1'b0;
        if (clr_req) begin
            if (bus.q_fb) begin
                arb = ARB_CLR;
            end
            pend_d = set_req;
        end else if (set_req || pend_q) begin
            if (!bus.q_fb) begin
                arb = ARB_SET;
            end
        end
    end

    // Saturating pulse counters.
    always_comb begin
        set_cnt_d = set_cnt_q;
        clr_cnt_d = clr_cnt_q;
        if (arb == ARB_SET && set_cnt_q != CNT_MAX) begin
            set_cnt_d = set_cnt_q + 1'b1;
        end
        if (arb == ARB_CLR && clr_cnt_q != CNT_MAX) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
        end
    end

    // Registered pulses, pending flag and counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            pend_q    <= 1'b0;
            set_cnt_q <= '0;
            clr_cnt_q <= '0;
        end else begin
            s_q       <= (arb == ARB_SET);
            r_q       <= (arb == ARB_CLR);
            pend_q    <= pend_d;
            set_cnt_q <= set_cnt_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign bus.S       = s_q;
    assign bus.R       = r_q;
    assign bus.busy    = set_busy | clr_busy | pend_q;
    assign bus.set_cnt = set_cnt_q;
    assign bus.clr_cnt = clr_cnt_q;

endmodule

// File: doc/sr_ctrl.md
SR_CTRL -- requirements
Module: sr_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4, is the number of consecutive stable synchronized cycles required to accept a level change (legal range 2..255).
REQ-002 Parameter CNT_W, default 8, is the width of each event counter.
REQ-003 Port clock, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-005 Port set_in, input, 1, is the raw asynchronous set request (button or external level).
REQ-006 Port clr_in, input, 1, is the raw asynchronous clear request.
REQ-007 Port q_fb, input, 1, is the Q output fed back from the downstream SR flip-flop.
REQ-008 Port S, output, 1, is the registered set pulse to the downstream SR flip-flop.
REQ-009 Port R, output, 1, is the registered reset pulse to the downstream SR flip-flop.
REQ-010 Port busy, output, 1, is high while any debounce count or deferred set is in progress.
REQ-011 Port set_cnt, output, CNT_W, counts issued S pulses.
REQ-012 Port clr_cnt, output, CNT_W, counts issued R pulses.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce: the per-channel counter increments on each cycle where synchronized input differs from the debounced level, and clears on any cycle they match.
REQ-015 When the counter reaches DEB_CYCLES mismatching cycles, the debounced level SHALL toggle and the counter SHALL clear in the same edge.
REQ-016 A debounced 0->1 transition SHALL produce a one-cycle internal request; 1->0 transitions produce nothing.
REQ-017 Latency: with a clean input, S or R SHALL be high for exactly the cycle following rising edge DEB_CYCLES+3, counted from the first edge that samples the input high.
REQ-018 S and R SHALL never be high in the same cycle.
REQ-019 A set request with q_fb=1, or a clear request with q_fb=0, SHALL be suppressed: no pulse and no count.
REQ-020 Simultaneous set and clear requests: R SHALL issue in that cycle, and set SHALL be held in a one-deep pending flag.
REQ-021 The pending set SHALL be evaluated in the next cycle against q_fb, with the REQ-019 rule applied.
REQ-022 A new clear request arriving in the cycle a pending set is evaluated SHALL win, and the pending set SHALL be discarded.
REQ-023 set_cnt and clr_cnt SHALL increment by one per issued pulse and saturate at all-ones, with no wrap.
REQ-024 Glitches shorter than DEB_CYCLES synchronized cycles SHALL produce no pulse and leave the debounced level unchanged.
REQ-025 Holding an input high indefinitely SHALL yield exactly one pulse; a new pulse requires a debounced release and then a debounced press.

Reset
REQ-026 While reset=0: S=0, R=0, busy=0, set_cnt=0, clr_cnt=0; synchronizers, debounced levels, debounce counters and the pending flag cleared.
REQ-027 Reset asserted mid-debounce or with a pending set SHALL discard all in-flight work.
REQ-028 After reset release, an input already high SHALL be treated as a new press, with a pulse after the REQ-017 latency.

Structure
REQ-029 Package sr_ctrl_pkg SHALL hold the DEB_CYCLES and CNT_W defaults and the debounce counter width constant (8 bits).
REQ-030 Sub-module sr_debounce (synchronizer, debounce counter, rise detect) SHALL be instantiated once per channel; arbitration, suppression, pending flag and counters sit in sr_ctrl.

Verification
REQ-031 DEB_CYCLES=4, q_fb=0, set_in held high -> S high one cycle after edge 7, set_cnt=1, R stays 0.
REQ-032 set_in pulsed high for 3 synchronized cycles -> no S, busy returns 0, set_cnt=0.
REQ-033 set_in and clr_in rise on the same edge with q_fb=1, and the model drives q_fb=0 after R -> R pulse in cycle t, S pulse in cycle t+1, both counters=1.
REQ-034 q_fb=1 and set_in pressed -> S stays 0 and set_cnt unchanged; clr_in then pressed -> one R pulse.
REQ-035 CNT_W=2 with 5 alternating set/clear presses -> counters saturate at 3.
REQ-036 reset asserted during debounce of set_in and released with set_in still high -> outputs 0 during reset, then one S pulse after DEB_CYCLES+3 edges.
